// File: rtl/regfile_rd_nport.sv
// regfile_rd_nport: parametrised register file, NUM_RD registered read ports, one write port, reg 0 reads zero
//   clk, rst (async, active-high) ; rd_en[NUM_RD], rd_addr[NUM_RD*ADDR_W] -> rd_data[NUM_RD*WIDTH], rd_valid[NUM_RD]
//   wr_en, wr_addr[ADDR_W], wr_data[WIDTH]
//   REGFILE_BYPASS_EN: same-edge write data is forwarded to matching reads
module regfile_rd_nport #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [WIDTH-1:0] val  [NUM_RD];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
    else if (wr_en)
      for (int r = 1; r < NUM_REGS; r++) if (wr_addr == ADDR_W'(r)) regs[r] <= wr_data;
  // address 0 and out-of-range addresses match no entry and fall through to zero
  always_comb
    for (int i = 0; i < NUM_RD; i++) begin
      val[i] = '0;
      for (int r = 1; r < NUM_REGS; r++)
        if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))
          val[i] = (BYPASS && wr_en && wr_addr == ADDR_W'(r)) ? wr_data : regs[r];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int i = 0; i < NUM_RD; i++) if (rd_en[i]) rd_data[i*WIDTH +: WIDTH] <= val[i];
    end
endmodule

// File: tb/tb_regfile_rd_nport.sv
// tb_regfile_rd_nport: randomized and directed check of regfile_rd_nport against an array model
module tb_regfile_rd_nport;
  localparam int NR = 24;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] model [32];
  logic [31:0] exp_d [2];
  int n_chk = 0;
  int n_fail = 0;
  regfile_rd_nport #(.WIDTH(32), .NUM_REGS(NR), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int a = 0; a < 32; a++) model[a] = '0;
    exp_d[0] = '0;
    exp_d[1] = '0;
  endtask
  task automatic step(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0] a;
    rd_en = en;
    rd_addr = {a1, a0};
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    for (int i = 0; i < 2; i++)
      if (en[i]) begin
        a = i ? a1 : a0;
        if (a == 0 || a >= NR) exp_d[i] = '0;
        else if (BYP && we && wa == a) exp_d[i] = wd;
        else exp_d[i] = model[a];
      end
    if (we && wa != 0 && wa < NR) model[wa] = wd;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(exp_d[i]));
      chk($sformatf("valid%0d", i), 64'(rd_valid[i]), 64'(en[i]));
    end
  endtask
  initial begin
    logic [4:0] wa, a0, a1;
    clear_model();
    #3;
    chk("rst_data", rd_data, 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) step(2'b11, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'd0);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    chk("rd5_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("rd5_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    chk("r0_zero", rd_data, 64'd0);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111);
    step(2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22222222);
    chk("collide", 64'(rd_data[31:0]), BYP ? 64'h22222222 : 64'h11111111);
    step(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0);
    chk("after_collide", 64'(rd_data[31:0]), 64'h22222222);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd23, 32'hA5A5A5A5);
    step(2'b11, 5'd30, 5'd23, 1'b1, 5'd30, 32'hCAFEF00D);
    chk("oor_read", 64'(rd_data[31:0]), 64'd0);
    step(2'b01, 5'd24, 5'd0, 1'b1, 5'd24, 32'h12345678);
    step(2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
    chk("hold_p1", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    for (int a = 0; a < 32; a++) step(2'b11, 5'(a), 5'(a), 1'b0, 5'd0, 32'd0);
    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(2'($urandom_range(0, 3)), a0, a1, 1'($urandom_range(0, 1)), wa, $urandom);
    end
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'h5A5A5A5A);
    step(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    step(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_data", rd_data, 64'd0);
    chk("async_valid", 64'(rd_valid), 64'd0);
    clear_model();
    rd_en = 2'b00;
    #1;
    rst = 1'b0;
    step(2'b00, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    step(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    chk("reg5_cleared", rd_data, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_rd_nport.md
Name: regfile_rd_nport

Overview:
- Parametrised general-purpose register file that replaces the fixed 32x32 hierarchical read mux.
- Provides NUM_RD registered read ports and one synchronous write port, with register 0 hardwired to zero.
- Sits between decode (read addresses) and writeback (write port) in the pipeline.
- Read data is captured into output registers, giving a fixed 1-cycle read latency.

Parameters:
- WIDTH, 32, data width of each register in bits.
- NUM_REGS, 32, number of architectural registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- ADDR_W, 5, width of each register address field.
- NUM_RD, 2, number of independent read ports; range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- rd_en  input  NUM_RD  per-port read strobe; bit i controls port i.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*WIDTH  packed registered read data; port i occupies bits [i*WIDTH +: WIDTH].
- rd_valid  output  NUM_RD  per-port flag, high for the one cycle after a read was accepted.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.

Behaviour:
- Reset: clk and rst form the single clock/reset pair; rst is asynchronous and active-high.
  - While rst is high, all NUM_REGS registers, all rd_data and all rd_valid clear to 0 immediately, independent of clk.
  - Deassertion is sampled on the next rising clk edge; the first edge with rst low performs normal operation.
- Write: on a rising edge with wr_en=1, wr_addr!=0 and wr_addr<NUM_REGS, reg[wr_addr] <= wr_data.
  - A write to address 0 is discarded.
  - A write to address >= NUM_REGS is discarded.
  - There is no error signal for discarded writes.
- Read, per port i:
  - On a rising edge with rd_en[i]=1, rd_data[i] <= value(rd_addr[i]) and rd_valid[i] <= 1.
  - On a rising edge with rd_en[i]=0, rd_data[i] holds its previous value and rd_valid[i] <= 0.
- Read value rules:
  - value(0) = 0 always.
  - value(a) for a >= NUM_REGS returns 0.
  - Otherwise value(a) is the register contents present before this edge's write (no bypass; see Optional Feature).
- Latency: address presented in cycle N gives data on rd_data in cycle N+1.
  - Back-to-back reads on every cycle are supported on all ports simultaneously.
- Ports are independent:
  - Any number of ports may read the same address in the same cycle, and all return identical data.
  - A read and a write to the same address in the same cycle do not stall either operation.
- Read-selection structure: one NUM_REGS:1 selection per port; no tristate nets.
- rst asserted mid-operation: any in-flight read result is lost; rd_valid is 0 in the cycle after reset release unless a new read is issued at that edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding is enabled.
  - If rd_en[i]=1, wr_en=1, rd_addr[i]==wr_addr, and wr_addr is nonzero and < NUM_REGS on the same edge, rd_data[i] <= wr_data (new value).
  - Address 0 still reads 0 even if written.
  - This removes the writeback-to-decode hazard in the pipeline.
- Undefined: no forwarding; a same-edge same-address read returns the old register value. The new value is visible from the next read onward.

Test Plan:
- Reset then read all: assert rst, release it, read addresses 0..31 on both ports -> every rd_data = 0x00000000 and rd_valid=1 one cycle after each read.
- Write then read: write reg5=0xDEADBEEF, next cycle read port0 addr5 and port1 addr5 -> both ports = 0xDEADBEEF at cycle+1.
- R0 protection: write reg0=0xFFFFFFFF, then read addr0 -> 0x00000000.
- Same-edge collision: reg7=0x11111111, then on one edge write reg7=0x22222222 and read addr7 -> 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; a following read returns 0x22222222 in both builds.
- Hold and out-of-range: NUM_REGS=24, write addr 30 and read addr 30 -> read = 0, regs unchanged; then drop rd_en -> rd_data holds the last value and rd_valid=0.
- Async reset mid-stream: with reads streaming, pulse rst between clock edges -> rd_data and rd_valid go to 0 immediately; reg5 reads 0 afterwards.
